cnn_core_scheduler: RTL and testbench

//  Dispatches convolution jobs to NUM_CORES cnn engine cores over their start/done pins.

---
 rtl/cnn_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/cnn_core_scheduler.sv | 165 ++++++++++++++++
 tb/tb_cnn_core_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared types and helpers for the multi-core CNN job scheduler.
package cnn_sched_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE      = 3'd0,
        CORE_START     = 3'd1,
        CORE_RUN       = 3'd2,
        CORE_DONE_WAIT = 3'd3,
        CORE_RELEASE   = 3'd4
    } core_state_e;

    localparam int DEFAULT_ID_W = 8;

    // Ceiling log2, usable in constant expressions for port and pointer widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter
    import cnn_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_core_scheduler.sv
// Queues incoming jobs, dispatches them round-robin to idle engine cores,
// reports completions on a registered valid/ready port and recycles each core.
module cnn_core_scheduler
    import cnn_sched_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int ID_W       = DEFAULT_ID_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        job_valid,
    input  logic [ID_W-1:0]             job_id,
    output logic                        job_ready,
    output logic [NUM_CORES-1:0]        core_start,
    output logic [NUM_CORES-1:0]        core_rst,
    input  logic [NUM_CORES-1:0]        core_done,
    output logic                        cmp_valid,
    output logic [ID_W-1:0]             cmp_id,
    output logic [clog2(NUM_CORES)-1:0] cmp_core,
    input  logic                        cmp_ready,
    output logic                        busy
);

    localparam int CW = clog2(NUM_CORES);
    localparam int AW = clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [ID_W-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 fifo_full, fifo_empty;
    logic                 push, pop;
    logic [ID_W-1:0]      fifo_head;
    logic                 ready_en_q;

    logic [CW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0] idle_vec, wait_vec, disp_req, disp_gnt;
    logic [NUM_CORES-1:0] owner_mask, cmp_req, consume;
    logic [ID_W-1:0]      slot_id [NUM_CORES];

    logic                 cmp_valid_q, cmp_valid_d;
    logic [ID_W-1:0]      cmp_id_q, cmp_id_d;
    logic [CW-1:0]        cmp_core_q, cmp_core_d;
    logic                 cmp_free;

    // Job queue: wrap-bit pointers distinguish full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign job_ready  = ready_en_q & ~fifo_full;
    assign push       = job_valid & job_ready;
    assign pop        = ~fifo_empty & (|idle_vec);
    assign wr_ptr_d   = wr_ptr_q + PW'(push);
    assign rd_ptr_d   = rd_ptr_q + PW'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= job_id;
        end
    end

    assign disp_req = pop ? idle_vec : '0;

    rr_arbiter #(
        .N  (NUM_CORES),
        .PW (CW)
    ) u_disp_arb (
        .req   (disp_req),
        .ptr   (rr_ptr_q),
        .grant (disp_gnt)
    );

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (disp_gnt[i]) begin
                rr_ptr_d = (i == NUM_CORES - 1) ? '0 : CW'(i + 1);
            end
        end
    end

    // The core whose record sits in the output register must not re-request.
    assign cmp_req  = wait_vec & ~owner_mask;
    assign cmp_free = ~cmp_valid_q | cmp_ready;

    always_comb begin
        cmp_valid_d = cmp_valid_q & ~cmp_ready;
        cmp_id_d    = cmp_id_q;
        cmp_core_d  = cmp_core_q;
        if (cmp_free) begin
            for (int i = NUM_CORES - 1; i >= 0; i--) begin
                if (cmp_req[i]) begin
                    cmp_valid_d = 1'b1;
                    cmp_core_d  = CW'(i);
                    cmp_id_d    = slot_id[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_en_q  <= 1'b0;
            rr_ptr_q    <= '0;
            cmp_valid_q <= 1'b0;
            cmp_id_q    <= '0;
            cmp_core_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ready_en_q  <= 1'b1;
            rr_ptr_q    <= rr_ptr_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_id_q    <= cmp_id_d;
            cmp_core_q  <= cmp_core_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        core_state_e     state_q, state_d;
        logic [ID_W-1:0] slot_id_q;

        assign owner_mask[gi] = cmp_valid_q && (cmp_core_q == CW'(gi));
        assign consume[gi]    = owner_mask[gi] & cmp_ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= CORE_IDLE;
                slot_id_q <= '0;
            end else begin
                state_q <= state_d;
                if (disp_gnt[gi]) begin
                    slot_id_q <= fifo_head;
                end
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                CORE_IDLE:      if (disp_gnt[gi])  state_d = CORE_START;
                CORE_START:                        state_d = CORE_RUN;
                CORE_RUN:       if (core_done[gi]) state_d = CORE_DONE_WAIT;
                CORE_DONE_WAIT: if (consume[gi])   state_d = CORE_RELEASE;
                CORE_RELEASE:                      state_d = CORE_IDLE;
                default:                           state_d = CORE_IDLE;
            endcase
        end

        assign idle_vec[gi]   = (state_q == CORE_IDLE);
        assign wait_vec[gi]   = (state_q == CORE_DONE_WAIT);
        assign core_start[gi] = (state_q == CORE_START);
        assign core_rst[gi]   = (state_q == CORE_RELEASE);
        assign slot_id[gi]    = slot_id_q;
    end

    assign cmp_valid = cmp_valid_q;
    assign cmp_id    = cmp_id_q;
    assign cmp_core  = cmp_core_q;
    assign busy      = ~(&idle_vec) | ~fifo_empty;

endmodule

// File: tb/tb_cnn_core_scheduler.sv
// Randomized bench for cnn_core_scheduler against a queue-based job/completion model.
module tb_cnn_core_scheduler;

    localparam int NC    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid;
    logic [7:0]    job_id;
    logic          job_ready;
    logic [NC-1:0] core_start, core_rst, core_done;
    logic          cmp_valid;
    logic [7:0]    cmp_id;
    logic [1:0]    cmp_core;
    logic          cmp_ready;
    logic          busy;

    cnn_core_scheduler #(.NUM_CORES(NC), .ID_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_id(job_id),
        .job_ready(job_ready), .core_start(core_start), .core_rst(core_rst),
        .core_done(core_done), .cmp_valid(cmp_valid), .cmp_id(cmp_id),
        .cmp_core(cmp_core), .cmp_ready(cmp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct { int cyc; int core; int id; } ev_t;
    ev_t start_log[$];
    ev_t cmp_log[$];
    ev_t rst_log[$];

    // Reference model: job queue, per-core occupancy and pending completion record.
    int          mq[$];
    bit [NC-1:0] m_hold, m_run, m_wait, m_start, m_rst;
    logic [7:0]  m_hid [NC];
    int          m_rr;
    bit          m_cv;
    int          m_cc;
    logic [7:0]  m_cid;
    bit          m_ready_en;

    always @(negedge clk) begin
        bit          acc, found;
        bit [NC-1:0] nstart, nrst;
        int          k;
        if (rst) begin
            chk("rst_outputs", {job_ready, core_start, core_rst, cmp_valid, cmp_id, cmp_core, busy}, 32'd0);
            mq.delete();
            m_hold = '0; m_run = '0; m_wait = '0; m_start = '0; m_rst = '0;
            m_rr = 0; m_cv = 1'b0; m_cc = 0; m_cid = '0; m_ready_en = 1'b0;
        end else begin
            chk("job_ready", job_ready, m_ready_en && (mq.size() < DEPTH));
            chk("core_start", core_start, m_start);
            chk("core_rst", core_rst, m_rst);
            chk("cmp_valid", cmp_valid, m_cv);
            if (m_cv) begin
                chk("cmp_id", cmp_id, m_cid);
                chk("cmp_core", cmp_core, m_cc);
            end
            chk("busy", busy, (mq.size() > 0) || (m_hold != 0));

            for (int i = 0; i < NC; i++) begin
                if (core_start[i]) start_log.push_back('{cyc, i, 0});
                if (core_rst[i])   rst_log.push_back('{cyc, i, 0});
            end
            if (cmp_valid && cmp_ready) begin
                cmp_log.push_back('{cyc, int'(cmp_core), int'(cmp_id)});
                $display("cycle %0d: completion id=%02h core=%0d", cyc, cmp_id, cmp_core);
            end

            acc    = m_ready_en && (mq.size() < DEPTH) && job_valid;
            nstart = '0;
            if (mq.size() > 0) begin
                for (int o = 0; o < NC; o++) begin
                    k = (m_rr + o) % NC;
                    if (!m_hold[k] && nstart == 0) begin
                        m_hold[k]  = 1'b1;
                        m_hid[k]   = 8'(mq.pop_front());
                        nstart[k]  = 1'b1;
                        m_rr       = (k + 1) % NC;
                    end
                end
            end
            if (acc) mq.push_back(int'(job_id));

            nrst = '0;
            if (m_cv && cmp_ready) nrst[m_cc] = 1'b1;
            if (!m_cv || cmp_ready) begin
                found = 1'b0;
                for (int i = 0; i < NC; i++) begin
                    if (!found && m_wait[i]) begin
                        found = 1'b1; m_cv = 1'b1; m_cc = i; m_cid = m_hid[i]; m_wait[i] = 1'b0;
                    end
                end
                if (!found) m_cv = 1'b0;
            end
            for (int i = 0; i < NC; i++) begin
                if (m_run[i] && core_done[i]) begin m_run[i] = 1'b0; m_wait[i] = 1'b1; end
            end
            m_run   = m_run | m_start;
            m_hold  = m_hold & ~m_rst;
            m_start = nstart;
            m_rst   = nrst;
            m_ready_en = 1'b1;
        end
        cyc++;
    end

    // Engine emulation: optional automatic finish after a random latency, done held until core_rst.
    bit auto_done = 1'b0;
    int cnt [NC];

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NC; i++) begin
            if (core_rst[i]) begin core_done[i] = 1'b0; cnt[i] = 0; end
            if (auto_done && core_start[i]) cnt[i] = $urandom_range(1, 6);
            else if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) core_done[i] = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; core_done = '0; job_valid = 1'b0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic send(input logic [7:0] id);
        job_valid = 1'b1; job_id = id;
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300 && busy; i++) step();
        chk(name, busy, 1'b0);
    endtask

    int acc_cyc, n99, nq, first_id;

    initial begin
        rst = 1'b1; job_valid = 1'b0; job_id = '0; core_done = '0; cmp_ready = 1'b1;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        step(); step();
        rst = 1'b0;
        chk("reset_job_ready_low", job_ready, 1'b0);
        step();
        chk("post_reset_job_ready", job_ready, 1'b1);

        // T1: single job latency and recycle
        start_log.delete(); cmp_log.delete(); rst_log.delete();
        acc_cyc = cyc;
        send(8'h11);
        for (int i = 0; i < 20 && start_log.size() == 0; i++) step();
        chk("t1_started", start_log.size() > 0, 1'b1);
        if (start_log.size() > 0) begin
            chk("t1_latency", start_log[0].cyc - acc_cyc, 2);
            chk("t1_core", start_log[0].core, 0);
        end
        core_done[0] = 1'b1;
        for (int i = 0; i < 20 && rst_log.size() == 0; i++) step();
        chk("t1_cmp_count", cmp_log.size(), 1);
        chk("t1_rst_count", rst_log.size(), 1);
        if (cmp_log.size() > 0 && rst_log.size() > 0) begin
            chk("t1_cmp_id", cmp_log[0].id, 8'h11);
            chk("t1_cmp_core", cmp_log[0].core, 0);
            chk("t1_rst_core", rst_log[0].core, 0);
            chk("t1_rst_after_hs", rst_log[0].cyc - cmp_log[0].cyc, 1);
        end
        wait_idle("t1_idle");

        // T2: five jobs, cores never finish; freeing core 2 runs the fifth job there
        do_reset();
        core_done[1] = 1'b1;
        step();
        core_done[1] = 1'b0;
        start_log.delete(); cmp_log.delete(); rst_log.delete();
        for (int j = 1; j <= 5; j++) send(8'(j));
        repeat (6) step();
        chk("t2_starts", start_log.size(), 4);
        for (int j = 0; j < 4 && j < start_log.size(); j++) chk("t2_start_order", start_log[j].core, j);
        core_done[2] = 1'b1;
        for (int i = 0; i < 30 && start_log.size() < 5; i++) step();
        chk("t2_fifth_start", start_log.size(), 5);
        if (start_log.size() == 5 && rst_log.size() > 0 && cmp_log.size() > 0) begin
            chk("t2_fifth_core", start_log[4].core, 2);
            chk("t2_after_release", start_log[4].cyc - rst_log[0].cyc, 2);
            chk("t2_core2_id", cmp_log[0].id, 8'h03);
        end

        // T3: full queue refuses a ninth job
        cmp_log.delete();
        for (int j = 0; j < 4; j++) send(8'h21 + 8'(j));
        chk("t3_full_ready", job_ready, 1'b0);
        job_valid = 1'b1; job_id = 8'h99;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("t3_refused", job_ready, 1'b0);
        end
        job_valid = 1'b0;
        auto_done = 1'b1;
        core_done = '1;
        wait_idle("t3_idle");
        auto_done = 1'b0;
        n99 = 0; nq = 0;
        foreach (cmp_log[j]) begin
            if (cmp_log[j].id == 8'h99) n99++;
            if (cmp_log[j].id >= 8'h21 && cmp_log[j].id <= 8'h24) nq++;
        end
        chk("t3_cmp_total", cmp_log.size(), 8);
        chk("t3_no_overwrite", n99, 0);
        chk("t3_queued_done", nq, 4);

        // T4: simultaneous done on cores 3 and 1
        for (int j = 0; j < 4; j++) send(8'h41 + 8'(j));
        repeat (6) step();
        cmp_log.delete(); rst_log.delete();
        core_done[1] = 1'b1; core_done[3] = 1'b1;
        repeat (8) step();
        chk("t4_cmp_count", cmp_log.size(), 2);
        chk("t4_rst_count", rst_log.size(), 2);
        if (cmp_log.size() == 2 && rst_log.size() == 2) begin
            chk("t4_first_core", cmp_log[0].core, 1);
            chk("t4_second_core", cmp_log[1].core, 3);
            chk("t4_back_to_back", cmp_log[1].cyc - cmp_log[0].cyc, 1);
            chk("t4_rst_first", rst_log[0].core, 1);
            chk("t4_rst_second", rst_log[1].core, 3);
        end
        core_done[0] = 1'b1; core_done[2] = 1'b1;
        wait_idle("t4_idle");

        // T5: completion held off by cmp_ready
        for (int j = 0; j < 4; j++) send(8'h51 + 8'(j));
        repeat (6) step();
        cmp_log.delete(); rst_log.delete();
        cmp_ready = 1'b0;
        core_done[2] = 1'b1;
        for (int i = 0; i < 10 && !cmp_valid; i++) step();
        chk("t5_valid", cmp_valid, 1'b1);
        first_id = int'(cmp_id);
        for (int j = 0; j < 5; j++) begin
            step();
            chk("t5_hold_valid", cmp_valid, 1'b1);
            chk("t5_hold_core", cmp_core, 2'd2);
            chk("t5_hold_id", cmp_id, first_id);
            chk("t5_no_rst", rst_log.size(), 0);
        end
        cmp_ready = 1'b1;
        for (int i = 0; i < 10 && rst_log.size() == 0; i++) step();
        chk("t5_rst_seen", rst_log.size(), 1);
        if (rst_log.size() == 1 && cmp_log.size() > 0) begin
            chk("t5_rst_core", rst_log[0].core, 2);
            chk("t5_rst_after_hs", rst_log[0].cyc - cmp_log[0].cyc, 1);
        end
        core_done[0] = 1'b1; core_done[1] = 1'b1; core_done[3] = 1'b1;
        wait_idle("t5_idle");

        // T6: reset with jobs running and queued
        for (int j = 0; j < 6; j++) send(8'h61 + 8'(j));
        repeat (3) step();
        chk("t6_busy_before", busy, 1'b1);
        rst = 1'b1; core_done = '0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        #1;
        chk("t6_outputs_zero", {job_ready, core_start, core_rst, cmp_valid, cmp_id, cmp_core, busy}, 32'd0);
        step(); step();
        rst = 1'b0;
        step(); step();
        chk("t6_busy_after", busy, 1'b0);
        chk("t6_ready_after", job_ready, 1'b1);

        // Randomized traffic
        auto_done = 1'b1;
        for (int j = 0; j < 1500; j++) begin
            job_valid = ($urandom_range(0, 99) < 40);
            job_id    = 8'($urandom);
            cmp_ready = ($urandom_range(0, 99) < 70);
            step();
        end
        job_valid = 1'b0;
        cmp_ready = 1'b1;
        wait_idle("random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
